// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: one responder on the bridge's per-device port.
// The timer loads PRESET, counts down once per clock, flags an interrupt, and then either stops or reloads.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        wr_ctrl, wr_preset;
  logic        en, im, auto_reload;

  // The bridge has already qualified the window, so only the word offset is decoded.
  logic        unused_addr;
  assign unused_addr = ^Addr[31:4];

  assign en          = ctrl_q[0];
  assign im          = ctrl_q[3];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = WE && (Addr[3:2] == 2'd0);
  assign wr_preset   = WE && (Addr[3:2] == 2'd1);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes override whatever the FSM wanted for the same register or flag.
    if (wr_ctrl) begin
      ctrl_d     = Din[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = Din;
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[3:2])
      2'd0:    Dout = {28'd0, ctrl_q};
      2'd1:    Dout = preset_q;
      2'd2:    Dout = count_q;
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_q & im;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a table of one-edge vectors plus hand-written reset sequences.
// Each vector optionally writes at a clock edge, then reads one offset and checks Dout and IRQ.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  localparam logic [31:2] BASE = 30'h1FC4;

  int checks_total;
  int checks_passed;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vq[$];

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, actual, expected);
  endtask

  task automatic addVec(input logic we, input logic [1:0] waddr, input logic [31:0] din,
                        input logic [1:0] raddr, input logic [31:0] exp_dout, input logic exp_irq);
    vec_t v;
    v.we = we; v.waddr = waddr; v.din = din;
    v.raddr = raddr; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
    vq.push_back(v);
  endtask

  // Idle cycle: no write, read one offset.
  task automatic addRead(input logic [1:0] raddr, input logic [31:0] exp_dout, input logic exp_irq);
    addVec(1'b0, 2'd0, 32'd0, raddr, exp_dout, exp_irq);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    WE   = v.we;
    Addr = BASE | 30'(v.waddr);
    Din  = v.din;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Addr = BASE | 30'(v.raddr);
    #1;
    checkOutput("dout", idx, Dout, v.exp_dout);
    checkOutput("irq", idx, 32'(IRQ), 32'(v.exp_irq));
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = BASE;
    Din   = '0;

    // One-shot, PRESET=3: IRQ five edges after CTRL write, EN then clears.
    addVec(1, 2'd1, 32'd3, 2'd1, 32'd3, 0);
    addVec(1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd3, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 1);
    addRead(2'd0, 32'h8, 1);
    addRead(2'd0, 32'h8, 1);
    addVec(1, 2'd0, 32'h8, 2'd0, 32'h8, 0);
    // Auto-reload, PRESET=2: period 5, COUNT 2,1,0,0,0.
    addVec(1, 2'd1, 32'd2, 2'd1, 32'd2, 0);
    addVec(1, 2'd0, 32'hB, 2'd0, 32'hB, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 1);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 1);
    addRead(2'd0, 32'hB, 0);
    // Disable while IDLE->LOAD is already committed; LOAD still copies PRESET.
    addVec(1, 2'd0, 32'h0, 2'd0, 32'h0, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd2, 0);
    // Masked: flag sets but IRQ stays 0; CTRL write clears the flag.
    addVec(1, 2'd1, 32'd1, 2'd1, 32'd1, 0);
    addVec(1, 2'd0, 32'h1, 2'd0, 32'h1, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd0, 32'h0, 0);
    addVec(1, 2'd0, 32'h8, 2'd0, 32'h8, 0);
    addRead(2'd0, 32'h8, 0);
    // Freeze: clear EN as COUNT reaches 6, it then holds.
    addVec(1, 2'd1, 32'd10, 2'd1, 32'd10, 0);
    addVec(1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd10, 0);
    addRead(2'd2, 32'd9, 0);
    addRead(2'd2, 32'd8, 0);
    addRead(2'd2, 32'd7, 0);
    addVec(1, 2'd0, 32'h8, 2'd2, 32'd6, 0);
    addRead(2'd2, 32'd6, 0);
    addRead(2'd2, 32'd6, 0);
    addRead(2'd2, 32'd6, 0);
    // Restart: COUNT write ignored, PRESET write deferred to next LOAD, reserved reads 0.
    addVec(1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addRead(2'd2, 32'd6, 0);
    addRead(2'd2, 32'd10, 0);
    addVec(1, 2'd2, 32'h55, 2'd2, 32'd9, 0);
    addVec(1, 2'd1, 32'd2, 2'd2, 32'd8, 0);
    addRead(2'd2, 32'd7, 0);
    addVec(1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'd0, 0);
    addVec(1, 2'd0, 32'h8, 2'd2, 32'd5, 0);
    addRead(2'd2, 32'd5, 0);
    addVec(1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addRead(2'd2, 32'd5, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 1);
    // CTRL write on the INT edge wins over the one-shot EN clear.
    addVec(1, 2'd0, 32'h9, 2'd0, 32'h9, 0);
    addRead(2'd2, 32'd0, 0);
    addRead(2'd2, 32'd2, 0);
    addRead(2'd2, 32'd1, 0);
    addRead(2'd2, 32'd0, 1);

    // Reset values at every offset.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int o = 0; o < 4; o++) begin
      Addr = BASE | 30'(o);
      #1;
      checkOutput("reset_dout", o, Dout, 32'd0);
    end
    checkOutput("reset_irq", 0, 32'(IRQ), 32'd0);

    for (int i = 0; i < vq.size(); i++) applyStimulus(vq[i], i);

    // Asynchronous reset between edges while IRQ is high.
    @(negedge clk);
    checkOutput("pre_areset_irq", 0, 32'(IRQ), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("areset_irq", 0, 32'(IRQ), 32'd0);
    for (int o = 0; o < 4; o++) begin
      Addr = BASE | 30'(o);
      #1;
      checkOutput("areset_dout", o, Dout, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer: the responder end of the system bridge's per-device interface (device address, write enable, write data in; read data out).
- Two instances sit behind the bridge, at word windows 0x7F00–0x7F0B and 0x7F10–0x7F1B.
- Each instance loads a preset, counts down once per clock, and raises an interrupt line toward the CPU.
- Supports a one-shot mode and an auto-reload mode.

Parameters:
- None. All registers are a fixed 32 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset. One clock; reset is asynchronous and active-low.
- Addr  input  [31:2]  device word address from the bridge. Only Addr[3:2] is decoded; the bridge has already qualified the window.
- WE  input  1  write enable, already qualified for this device by the bridge.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr[3:2].
- IRQ  output  1  interrupt request, level.

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL, read/write. Bit0 EN, bits[2:1] MODE, bit3 IM. Bits[31:4] are not stored and read 0.
  - 1 = PRESET, read/write, 32 bits.
  - 2 = COUNT, read-only. Writes are ignored.
  - 3 = reserved. Reads 0; writes are ignored.
- Reset (reset low, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Dout follows the registers, so it reads 0 at every offset; IRQ=0.
- MODE encoding: 00 = one-shot, 01 = auto-reload. 10 and 11 behave as 00.
- IRQ = irq_flag & CTRL.IM, combinational.
- Bus write: a write with WE=1 updates the addressed register at the clock edge.
  - A bus write to CTRL or PRESET also clears irq_flag at the same edge.
  - A bus write has priority over any FSM update of the same register or flag at the same edge.
- FSM transitions, evaluated at each rising edge:
  - IDLE: if EN=1, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0: go to IDLE; COUNT holds its current value.
    - Else if COUNT > 1 (unsigned): COUNT <= COUNT-1.
    - Else: COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - One-shot: CTRL.EN <= 0, go to IDLE. irq_flag stays 1 until a write to CTRL or PRESET.
    - Auto-reload: irq_flag <= 0, go to IDLE. EN stays 1, so the timer reloads.
- Latency:
  - IRQ rises PRESET+2 edges after the edge that writes EN=1 with IM=1, for PRESET ≥ 1.
  - PRESET=0 behaves like PRESET=1.
  - Auto-reload period is PRESET+3 cycles, with IRQ high for exactly 1 cycle per period.
- EN is sampled each cycle. Clearing EN mid-count freezes COUNT; setting EN again restarts from LOAD, re-reading PRESET.
- A PRESET write during CNT does not affect the current countdown. It takes effect at the next LOAD.
- COUNT wraps never: the decrement stops at 0; no underflow.
- Reset asserted mid-count aborts immediately; IRQ drops asynchronously.

Test Plan:
- Reset values: hold reset low, then release; read offsets 0, 4, 8, 0xC -> all 0x0; IRQ=0.
- One-shot: write PRESET=3, then CTRL=0x9.
  - -> COUNT reads 3, 2, 1 on successive cycles, then 0.
  - -> IRQ rises exactly 5 edges after the CTRL write.
  - -> CTRL then reads 0x8.
  - -> IRQ stays high until a write of CTRL=0x8, which drops it at that edge.
- Auto-reload: PRESET=2, CTRL=0xB.
  - -> IRQ pulses high for 1 cycle, every 5 cycles.
  - -> CTRL stays 0xB.
  - -> COUNT sequence is 2, 1, 0, 0, 0 repeating.
- Mask and disable:
  - CTRL=0x1 (IM=0), PRESET=1 -> COUNT reaches 0 and EN clears, but IRQ stays 0.
  - Then write CTRL=0x8 -> IRQ remains 0, because the write clears irq_flag.
  - Separately: start PRESET=10, write CTRL=0x8 when COUNT=6 -> COUNT holds at 6 indefinitely.
- Collisions:
  - Write COUNT=0x55 during CNT -> ignored.
  - Write CTRL=0x9 on the same edge as one-shot INT clears EN -> CTRL reads 0x9 and the timer reloads.
- Async reset: assert reset low between clock edges while IRQ=1 -> IRQ and all registers go 0 before the next edge.
